// File: rtl/usb_pkg.sv
// Constants and state encoding shared by the USB transmit framer and the
// receive-side sync/EOP detector.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP1,
        ST_EOP2,
        ST_EOPJ
    } tx_state_e;

    // Emitted LSB first: 0,0,0,0,0,0,1,1.
    localparam logic [7:0] SYNC_PATTERN = 8'b1100_0000;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam int         SE0_BITS     = 2;

    // Length of the run of ones that closes the pattern on the wire; the
    // stuffing run counter starts from this value at the first payload bit.
    function automatic logic [2:0] sync_tail_ones(input logic [7:0] pattern);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!pattern[i]) break;
            n = n + 3'd1;
        end
        return n;
    endfunction

    localparam logic [2:0] SYNC_TAIL_ONES = sync_tail_ones(SYNC_PATTERN);

endpackage

// File: rtl/sync_eop_generator_if.sv
// Byte-feed handshake and line-side outputs of the transmit framer.
interface sync_eop_generator_if;

    logic       Tx_Start;
    logic [7:0] Tx_Byte;
    logic       Tx_Byte_Valid;
    logic       Tx_Last;
    logic       Tx_Byte_Ready;
    logic       Tx_Data;
    logic       Tx_Diff;
    logic       Tx_OE;
    logic       Tx_Busy;
    logic       Tx_Underrun;

    modport master (
        output Tx_Start, Tx_Byte, Tx_Byte_Valid, Tx_Last,
        input  Tx_Byte_Ready, Tx_Data, Tx_Diff, Tx_OE, Tx_Busy, Tx_Underrun
    );

    modport slave (
        input  Tx_Start, Tx_Byte, Tx_Byte_Valid, Tx_Last,
        output Tx_Byte_Ready, Tx_Data, Tx_Diff, Tx_OE, Tx_Busy, Tx_Underrun
    );

endinterface

// File: rtl/tx_byte_holding.sv
// Single-entry valid/ready buffer holding the next payload byte and its
// last-byte flag until the framer loads it into the shift register.
module tx_byte_holding
    import usb_pkg::*;
(
    input  logic       Sync_Detector_Clk,
    input  logic       Reset,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic       take,
    output logic       ready,
    output logic       full,
    output logic [7:0] data,
    output logic       last
);

    assign ready = !full;

    // NOTE: sequential state uses non-blocking assignments only; the data
    // and last flag are reset too, so a stale byte never leaks after an abort.
    always_ff @(posedge Sync_Detector_Clk) begin
        if (Reset) begin
            full <= 1'b0;
            data <= '0;
            last <= 1'b0;
        end else if (take) begin
            full <= 1'b0;
        end else if (wr_valid && !full) begin
            full <= 1'b1;
            data <= wr_data;
            last <= wr_last;
        end
    end

endmodule

// File: rtl/sync_eop_generator.sv
// Transmit framer: SYNC, bit-stuffed LSB-first payload, then SE0,SE0,J EOP,
// one NRZ bit per clock with all outputs registered.
module sync_eop_generator
    import usb_pkg::*;
(
    input  logic                 Sync_Detector_Clk,
    input  logic                 Reset,
    sync_eop_generator_if.slave  tx
);

    tx_state_e  state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [2:0] ones_cnt, ones_cnt_nxt;
    logic [7:0] shift_reg, shift_nxt;
    logic       shift_last, shift_last_nxt;
    logic       boundary_pend, boundary_pend_nxt;
    logic       at_boundary;
    logic       take;
    logic       underrun_nxt;
    logic [2:0] ones_inc;
    logic       data_nxt, diff_nxt, oe_nxt;

    logic       hold_full;
    logic [7:0] hold_data;
    logic       hold_last;

    tx_byte_holding u_holding (
        .Sync_Detector_Clk (Sync_Detector_Clk),
        .Reset             (Reset),
        .wr_valid          (tx.Tx_Byte_Valid),
        .wr_data           (tx.Tx_Byte),
        .wr_last           (tx.Tx_Last),
        .take              (take),
        .ready             (tx.Tx_Byte_Ready),
        .full              (hold_full),
        .data              (hold_data),
        .last              (hold_last)
    );

    assign ones_inc = shift_reg[0] ? ones_cnt + 3'd1 : 3'd0;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt         = state;
        bit_cnt_nxt       = bit_cnt;
        ones_cnt_nxt      = ones_cnt;
        shift_nxt         = shift_reg;
        shift_last_nxt    = shift_last;
        boundary_pend_nxt = boundary_pend;
        at_boundary       = 1'b0;
        take              = 1'b0;
        underrun_nxt      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (tx.Tx_Start && hold_full) begin
                    state_nxt   = ST_SYNC;
                    bit_cnt_nxt = 3'd0;
                end
            end
            ST_SYNC: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    take           = 1'b1;
                    shift_nxt      = hold_data;
                    shift_last_nxt = hold_last;
                    ones_cnt_nxt   = SYNC_TAIL_ONES;
                    state_nxt      = ST_DATA;
                end
            end
            ST_DATA: begin
                shift_nxt    = {1'b0, shift_reg[7:1]};
                bit_cnt_nxt  = bit_cnt + 3'd1;
                ones_cnt_nxt = ones_inc;
                if (ones_inc == STUFF_LIMIT) begin
                    state_nxt         = ST_STUFF;
                    boundary_pend_nxt = (bit_cnt == 3'd7);
                end else if (bit_cnt == 3'd7) begin
                    at_boundary = 1'b1;
                end
            end
            ST_STUFF: begin
                ones_cnt_nxt      = 3'd0;
                boundary_pend_nxt = 1'b0;
                if (boundary_pend) at_boundary = 1'b1;
                else               state_nxt   = ST_DATA;
            end
            ST_EOP1: state_nxt = (SE0_BITS > 1) ? ST_EOP2 : ST_EOPJ;
            ST_EOP2: state_nxt = ST_EOPJ;
            ST_EOPJ: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Byte boundary: finish, reload the next byte, or report starvation.
        if (at_boundary) begin
            if (shift_last) begin
                state_nxt = ST_EOP1;
            end else if (hold_full) begin
                take           = 1'b1;
                shift_nxt      = hold_data;
                shift_last_nxt = hold_last;
                state_nxt      = ST_DATA;
            end else begin
                underrun_nxt = 1'b1;
                state_nxt    = ST_EOP1;
            end
        end
    end

    // Line outputs are decoded from the next state so they register with it.
    always_comb begin
        data_nxt = 1'b1;
        diff_nxt = 1'b1;
        oe_nxt   = 1'b1;
        case (state_nxt)
            ST_IDLE:  oe_nxt   = 1'b0;
            ST_SYNC:  data_nxt = SYNC_PATTERN[bit_cnt_nxt];
            ST_DATA:  data_nxt = shift_nxt[0];
            ST_STUFF: data_nxt = 1'b0;
            ST_EOP1, ST_EOP2: begin
                data_nxt = 1'b0;
                diff_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Sync_Detector_Clk) begin
        if (Reset) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            ones_cnt       <= '0;
            shift_reg      <= '0;
            shift_last     <= 1'b0;
            boundary_pend  <= 1'b0;
            tx.Tx_Data     <= 1'b1;
            tx.Tx_Diff     <= 1'b1;
            tx.Tx_OE       <= 1'b0;
            tx.Tx_Busy     <= 1'b0;
            tx.Tx_Underrun <= 1'b0;
        end else begin
            state          <= state_nxt;
            bit_cnt        <= bit_cnt_nxt;
            ones_cnt       <= ones_cnt_nxt;
            shift_reg      <= shift_nxt;
            shift_last     <= shift_last_nxt;
            boundary_pend  <= boundary_pend_nxt;
            tx.Tx_Data     <= data_nxt;
            tx.Tx_Diff     <= diff_nxt;
            tx.Tx_OE       <= oe_nxt;
            tx.Tx_Busy     <= (state_nxt != ST_IDLE);
            tx.Tx_Underrun <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_sync_eop_generator.sv
// Self-checking bench for sync_eop_generator: directed framing cases plus
// randomized packets compared cycle by cycle against a bit-stream model.
module tb_sync_eop_generator;

    typedef struct packed {
        logic oe;
        logic diff;
        logic data;
        logic busy;
        logic und;
    } obs_t;

    logic Sync_Detector_Clk = 1'b0;
    logic Reset             = 1'b1;

    sync_eop_generator_if tx ();

    sync_eop_generator dut (
        .Sync_Detector_Clk (Sync_Detector_Clk),
        .Reset             (Reset),
        .tx                (tx)
    );

    always #5 Sync_Detector_Clk = ~Sync_Detector_Clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   pkt_id   = 0;
    int   exp_oe_len;
    logic [7:0] pay_q[$];
    obs_t       exp_q[$];
    bit         sync_seq [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic obs_t mk(input logic oe, diff, data, busy, und);
        obs_t r;
        r.oe = oe; r.diff = diff; r.data = data; r.busy = busy; r.und = und;
        return r;
    endfunction

    function automatic obs_t sample();
        return mk(tx.Tx_OE, tx.Tx_Diff, tx.Tx_Data, tx.Tx_Busy, tx.Tx_Underrun);
    endfunction

    // Wire-level picture of a packet: stuff a zero after every run of six
    // ones counted across the whole stream, SYNC included, but never insert
    // into SYNC itself.
    function automatic void build_expected(input bit starve);
        int run;
        int stuffed;
        bit b;
        exp_q.delete();
        run     = 0;
        stuffed = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(1, 1, sync_seq[i], 1, 0));
            run = sync_seq[i] ? run + 1 : 0;
        end
        foreach (pay_q[j]) begin
            for (int i = 0; i < 8; i++) begin
                b = pay_q[j][i];
                exp_q.push_back(mk(1, 1, b, 1, 0));
                run = b ? run + 1 : 0;
                if (run == 6) begin
                    exp_q.push_back(mk(1, 1, 0, 1, 0));
                    run = 0;
                    stuffed++;
                end
            end
        end
        exp_q.push_back(mk(1, 0, 0, 1, starve));
        exp_q.push_back(mk(1, 0, 0, 1, 0));
        exp_q.push_back(mk(1, 1, 1, 1, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 0));
        exp_oe_len = 8 + 8 * pay_q.size() + stuffed + 3;
    endfunction

    task automatic write_byte(input logic [7:0] b, input logic last);
        tx.Tx_Byte       = b;
        tx.Tx_Last       = last;
        tx.Tx_Byte_Valid = 1'b1;
        @(negedge Sync_Detector_Clk);
        tx.Tx_Byte_Valid = 1'b0;
        tx.Tx_Last       = 1'b0;
    endtask

    // Loads byte 0, pulses Start, then feeds the rest while checking every
    // cycle of the packet against the model.
    task automatic run_packet(input bit starve, input int wr_delay, input bit poke, input int exp_oe);
        int n;
        n = pay_q.size();
        pkt_id++;
        build_expected(starve);
        @(negedge Sync_Detector_Clk);
        write_byte(pay_q[0], (n == 1) && !starve);
        tx.Tx_Start = 1'b1;
        @(negedge Sync_Detector_Clk);
        tx.Tx_Start = 1'b0;
        fork
            begin : feeder
                for (int i = 1; i < n; i++) begin
                    int guard;
                    int d;
                    guard = 0;
                    while (!tx.Tx_Byte_Ready && guard < 200) begin
                        @(negedge Sync_Detector_Clk);
                        guard++;
                    end
                    check($sformatf("pkt%0d_ready_b%0d", pkt_id, i), tx.Tx_Byte_Ready, 1);
                    d = (wr_delay < 0) ? int'($urandom_range(0, 3)) : wr_delay;
                    repeat (d) @(negedge Sync_Detector_Clk);
                    write_byte(pay_q[i], (i == n - 1) && !starve);
                end
            end
            begin : monitor
                int oe_cnt;
                obs_t got;
                oe_cnt = 0;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (k > 0) @(negedge Sync_Detector_Clk);
                    got = sample();
                    if (got.oe) oe_cnt++;
                    check($sformatf("pkt%0d_cyc%0d", pkt_id, k), got, exp_q[k]);
                    if (poke && k == 10) tx.Tx_Start = 1'b1;
                    if (poke && k == 11) tx.Tx_Start = 1'b0;
                end
                check($sformatf("pkt%0d_oe_len", pkt_id), oe_cnt, exp_oe_len);
                if (exp_oe > 0) check($sformatf("pkt%0d_oe_len_const", pkt_id), oe_cnt, exp_oe);
            end
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        tx.Tx_Start      = 1'b0;
        tx.Tx_Byte       = 8'h00;
        tx.Tx_Byte_Valid = 1'b0;
        tx.Tx_Last       = 1'b0;
        repeat (3) @(negedge Sync_Detector_Clk);
        check("reset_obs",   sample(), mk(0, 1, 1, 0, 0));
        check("reset_ready", tx.Tx_Byte_Ready, 1);
        Reset = 1'b0;
        @(negedge Sync_Detector_Clk);

        // 0x00: no stuffing, 19 cycles of OE.
        pay_q = '{8'h00};
        run_packet(0, 0, 0, 19);

        // 0xFF: run from SYNC tail forces a stuff after four payload ones.
        pay_q = '{8'hFF};
        run_packet(0, 0, 0, 20);

        // Two bytes, second written one cycle after Ready rises.
        pay_q = '{8'hA5, 8'h3C};
        run_packet(0, 1, 0, 0);

        // Starved packet with a Start pulse while busy.
        pay_q = '{8'h12};
        run_packet(1, 0, 1, 0);

        // Start with holding empty is ignored.
        @(negedge Sync_Detector_Clk);
        tx.Tx_Start = 1'b1;
        @(negedge Sync_Detector_Clk);
        tx.Tx_Start = 1'b0;
        repeat (3) @(negedge Sync_Detector_Clk);
        check("start_empty_obs", sample(), mk(0, 1, 1, 0, 0));

        // Reset on the fourth SYNC bit aborts the packet without EOP.
        @(negedge Sync_Detector_Clk);
        write_byte(8'h5A, 1'b1);
        tx.Tx_Start = 1'b1;
        @(negedge Sync_Detector_Clk);
        tx.Tx_Start = 1'b0;
        repeat (3) @(negedge Sync_Detector_Clk);
        check("rst_sync3_obs", sample(), mk(1, 1, 0, 1, 0));
        Reset = 1'b1;
        @(negedge Sync_Detector_Clk);
        check("rst_abort_obs",   sample(), mk(0, 1, 1, 0, 0));
        check("rst_abort_ready", tx.Tx_Byte_Ready, 1);
        Reset       = 1'b0;
        tx.Tx_Start = 1'b1;
        @(negedge Sync_Detector_Clk);
        tx.Tx_Start = 1'b0;
        repeat (3) @(negedge Sync_Detector_Clk);
        check("rst_then_start_obs", sample(), mk(0, 1, 1, 0, 0));

        // Randomized packets: lengths 1-4, ones-heavy bytes, random feed delay.
        for (int p = 0; p < 24; p++) begin
            int n;
            n = int'($urandom_range(1, 4));
            pay_q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       pay_q.push_back(8'hFF);
                    1:       pay_q.push_back(8'(($urandom & 32'hFF) | 32'hF0));
                    default: pay_q.push_back(8'($urandom & 32'hFF));
                endcase
            end
            run_packet($urandom_range(0, 5) == 0, -1, $urandom_range(0, 1) == 1, 0);
            repeat (int'($urandom_range(0, 3))) @(negedge Sync_Detector_Clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
